// File: rtl/idx_rmw_pkg.sv
// Shared types and constants for the indexed read-modify-write sequencer.
package idx_rmw_pkg;

  localparam int unsigned XPT_W = 4;

  typedef enum logic [3:0] {
    IDLE, DISP, ADDR, R0, R1, R2, ALU, W0, W1, W2, DONE, ABORT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_INC = 3'd1,
    ALU_DEC = 3'd2,
    ALU_ROT = 3'd3,
    ALU_BIT = 3'd4,
    ALU_RES = 3'd5,
    ALU_SET = 3'd6
  } alu_op_e;

  localparam logic [7:0] OP_INC = 8'h34;
  localparam logic [7:0] OP_DEC = 8'h35;
  localparam logic [7:0] OP_CB  = 8'hCB;

  // CB group select (cb_op[7:6]) to ALU operation
  function automatic alu_op_e cb_alu_op(input logic [1:0] sel);
    case (sel)
      2'b00:   return ALU_ROT;
      2'b01:   return ALU_BIT;
      2'b10:   return ALU_RES;
      default: return ALU_SET;
    endcase
  endfunction

endpackage

// File: rtl/idx_rmw_sequencer_if.sv
// Instruction/memory handshake and control strobes of the RMW sequencer.
interface idx_rmw_sequencer_if;
  import idx_rmw_pkg::*;

  logic              start;
  logic [7:0]        opcode;
  logic [7:0]        cb_op;
  logic              prefix_iy;
  logic              mem_wait;
  logic              busy;
  logic [XPT_W-1:0]  XPT;
  logic              dtex_we;
  logic              dt_we;
  logic              flags_we;
  logic              ad_alu;
  logic              idx_sel_iy;
  logic [2:0]        rd_ph;
  logic [2:0]        wr_ph;
  alu_op_e           alu_op;
  logic              done;
  logic              illegal;
  logic              abort;

  modport master (
    output start, opcode, cb_op, prefix_iy, mem_wait,
    input  busy, XPT, dtex_we, dt_we, flags_we, ad_alu, idx_sel_iy,
           rd_ph, wr_ph, alu_op, done, illegal, abort
  );

  modport slave (
    input  start, opcode, cb_op, prefix_iy, mem_wait,
    output busy, XPT, dtex_we, dt_we, flags_we, ad_alu, idx_sel_iy,
           rd_ph, wr_ph, alu_op, done, illegal, abort
  );
endinterface

// File: rtl/idx_rmw_waitctr.sv
// Consecutive memory wait-cycle counter with timeout flag.
module idx_rmw_waitctr #(
  parameter int unsigned WAIT_MAX = 7
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic timeout_c
);
  localparam int unsigned CW = 8;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET)                   cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && !timeout_c)  cnt <= cnt + CW'(1);
  end

  assign timeout_c = (cnt == CW'(WAIT_MAX));
endmodule

// File: rtl/idx_rmw_sequencer.sv
// Indexed (IX/IY + displacement) read-modify-write instruction sequencer.
// Build option: IDX_RMW_CB_EN enables the 0xCB rotate/bit/res/set group.
module idx_rmw_sequencer
  import idx_rmw_pkg::*;
#(
  parameter int unsigned ADDR_CYCLES = 5,
  parameter int unsigned WAIT_MAX    = 7
) (
  input logic                CLK,
  input logic                RESET,
  idx_rmw_sequencer_if.slave bus
);
  localparam int unsigned ACW = 3;

  state_e           state, next_state;
  logic [ACW-1:0]   addr_cnt;
  alu_op_e          op_q, dec_op_c, alu_d;
  logic             legal_c, accept_c, in_wait_c, timeout_c;
  logic             unused_cb;
  logic             busy_d, dtex_d, ad_d, dt_d, fl_d, illegal_d, done_d, abort_d;
  logic [2:0]       rd_d, wr_d;
  logic [XPT_W-1:0] xpt_d;

  // opcode legality and operation select
  always_comb begin
    legal_c  = 1'b1;
    dec_op_c = ALU_ADD;
    case (bus.opcode)
      OP_INC:  dec_op_c = ALU_INC;
      OP_DEC:  dec_op_c = ALU_DEC;
`ifdef IDX_RMW_CB_EN
      OP_CB:   dec_op_c = cb_alu_op(bus.cb_op[7:6]);
`endif
      default: legal_c = 1'b0;
    endcase
  end

`ifdef IDX_RMW_CB_EN
  assign unused_cb = ^bus.cb_op[5:0];
`else
  assign unused_cb = ^bus.cb_op;
`endif

  assign accept_c  = (state == IDLE) && bus.start && legal_c;
  assign in_wait_c = (state == R1) || (state == W1);

  idx_rmw_waitctr #(.WAIT_MAX(WAIT_MAX)) u_waitctr (
    .CLK       (CLK),
    .RESET     (RESET),
    .clr       (!in_wait_c),
    .inc       (in_wait_c && bus.mem_wait),
    .timeout_c (timeout_c)
  );

  // next state and registered-output decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c) next_state = DISP;
      DISP:    next_state = ADDR;
      ADDR:    if (addr_cnt == ACW'(ADDR_CYCLES - 1)) next_state = R0;
      R0:      next_state = R1;
      R1:      if (!bus.mem_wait) next_state = R2;
               else if (timeout_c) next_state = ABORT;
      R2:      next_state = ALU;
      ALU:     next_state = (op_q == ALU_BIT) ? DONE : W0;
      W0:      next_state = W1;
      W1:      if (!bus.mem_wait) next_state = W2;
               else if (timeout_c) next_state = ABORT;
      W2:      next_state = DONE;
      DONE:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase

    busy_d    = (next_state != IDLE);
    dtex_d    = (next_state == DISP);
    ad_d      = (next_state == ADDR);
    rd_d      = {next_state == R2, next_state == R1, next_state == R0};
    wr_d      = {next_state == W2, next_state == W1, next_state == W0};
    fl_d      = (next_state == ALU);
    dt_d      = (next_state == R2) || ((next_state == ALU) && (op_q != ALU_BIT));
    alu_d     = (next_state == ALU) ? op_q : ALU_ADD;
    illegal_d = (state == IDLE) && bus.start && !legal_c;
    done_d    = (state == DONE);
    abort_d   = (state == ABORT);

    // phase count holds while a wait state repeats and saturates at all-ones
    if (next_state == IDLE)                       xpt_d = '0;
    else if (in_wait_c && (next_state == state))  xpt_d = bus.XPT;
    else if (bus.XPT == {XPT_W{1'b1}})            xpt_d = bus.XPT;
    else                                          xpt_d = bus.XPT + XPT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= IDLE;
      addr_cnt       <= '0;
      op_q           <= ALU_ADD;
      bus.idx_sel_iy <= 1'b0;
      bus.busy       <= 1'b0;
      bus.XPT        <= '0;
      bus.dtex_we    <= 1'b0;
      bus.ad_alu     <= 1'b0;
      bus.rd_ph      <= '0;
      bus.wr_ph      <= '0;
      bus.dt_we      <= 1'b0;
      bus.flags_we   <= 1'b0;
      bus.alu_op     <= ALU_ADD;
      bus.illegal    <= 1'b0;
      bus.done       <= 1'b0;
      bus.abort      <= 1'b0;
    end else begin
      state    <= next_state;
      addr_cnt <= (state == ADDR) ? addr_cnt + ACW'(1) : '0;
      if (accept_c) begin
        op_q           <= dec_op_c;
        bus.idx_sel_iy <= bus.prefix_iy;
      end
      bus.busy     <= busy_d;
      bus.XPT      <= xpt_d;
      bus.dtex_we  <= dtex_d;
      bus.ad_alu   <= ad_d;
      bus.rd_ph    <= rd_d;
      bus.wr_ph    <= wr_d;
      bus.dt_we    <= dt_d;
      bus.flags_we <= fl_d;
      bus.alu_op   <= alu_d;
      bus.illegal  <= illegal_d;
      bus.done     <= done_d;
      bus.abort    <= abort_d;
    end
  end
endmodule

// File: tb/tb_idx_rmw_sequencer.sv
// Self-checking bench for idx_rmw_sequencer: per-cycle output timeline from a phase-list model.
module tb_idx_rmw_sequencer;
  localparam int AC = 5;
  localparam int WM = 7;
`ifdef IDX_RMW_CB_EN
  localparam bit CB_EN = 1'b1;
`else
  localparam bit CB_EN = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic [3:0] xpt;
    logic       dtex, ad;
    logic [2:0] rd, wr;
    logic       dt, fl;
    logic [2:0] alu;
    logic       done, illegal, abort;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic mw;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  step_t q[$];
  int   xm;

  idx_rmw_sequencer_if bus ();

  idx_rmw_sequencer #(.ADDR_CYCLES(AC), .WAIT_MAX(WM)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.busy = bus.busy;      o.xpt = bus.XPT;
    o.dtex = bus.dtex_we;   o.ad = bus.ad_alu;
    o.rd = bus.rd_ph;       o.wr = bus.wr_ph;
    o.dt = bus.dt_we;       o.fl = bus.flags_we;
    o.alu = 3'(bus.alu_op);
    o.done = bus.done;      o.illegal = bus.illegal;  o.abort = bus.abort;
    return o;
  endfunction

  function automatic step_t blank(input bit busy);
    step_t s = '0;
    s.o.busy = busy;
    return s;
  endfunction

  function automatic step_t ph_step(input bit is_rd, input logic [2:0] ph);
    step_t s = blank(1'b1);
    if (is_rd) s.o.rd = ph;
    else       s.o.wr = ph;
    return s;
  endfunction

  // append one cycle; phase count advances on every busy cycle that is not a wait repeat
  task automatic emit(input step_t s, input bit hold);
    step_t t = s;
    if (t.o.busy) begin
      if (!hold && xm < 15) xm++;
      t.o.xpt = 4'(xm);
    end else begin
      xm = 0;
      t.o.xpt = 4'd0;
    end
    q.push_back(t);
  endtask

  task automatic mem_phase(input bit is_rd, input int n, output bit ok);
    step_t s;
    emit(ph_step(is_rd, 3'b001), 1'b0);
    if (n > WM) begin
      for (int j = 0; j <= WM; j++) begin
        s = ph_step(is_rd, 3'b010);
        s.mw = 1'b1;
        emit(s, j > 0);
      end
      emit(blank(1'b1), 1'b0);
      s = blank(1'b0);
      s.o.abort = 1'b1;
      emit(s, 1'b0);
      emit(blank(1'b0), 1'b0);
      ok = 1'b0;
      return;
    end
    for (int j = 0; j <= n; j++) begin
      s = ph_step(is_rd, 3'b010);
      s.mw = (j < n);
      emit(s, j > 0);
    end
    ok = 1'b1;
  endtask

  task automatic build(input logic [2:0] aop, input bit isbit, input int nr, input int nw);
    step_t s;
    bit ok;
    q.delete();
    xm = 0;
    s = blank(1'b1); s.o.dtex = 1'b1; emit(s, 1'b0);
    for (int k = 0; k < AC; k++) begin
      s = blank(1'b1); s.o.ad = 1'b1; emit(s, 1'b0);
    end
    mem_phase(1'b1, nr, ok);
    if (!ok) return;
    s = ph_step(1'b1, 3'b100); s.o.dt = 1'b1; emit(s, 1'b0);
    s = blank(1'b1); s.o.fl = 1'b1; s.o.dt = !isbit; s.o.alu = aop; emit(s, 1'b0);
    if (!isbit) begin
      mem_phase(1'b0, nw, ok);
      if (!ok) return;
      emit(ph_step(1'b0, 3'b100), 1'b0);
    end
    emit(blank(1'b1), 1'b0);
    s = blank(1'b0); s.o.done = 1'b1; emit(s, 1'b0);
    emit(blank(1'b0), 1'b0);
  endtask

  task automatic ref_decode(input logic [7:0] op, input logic [1:0] cbsel,
                            output bit legal, output logic [2:0] aop, output bit isbit);
    legal = 1'b1;
    isbit = 1'b0;
    aop   = 3'd0;
    if (op == 8'h34) aop = 3'd1;
    else if (op == 8'h35) aop = 3'd2;
    else if (CB_EN && op == 8'hCB) begin
      aop   = 3'd3 + 3'(cbsel);
      isbit = (cbsel == 2'b01);
    end else legal = 1'b0;
  endtask

  task automatic prepare(input logic [7:0] op, input logic [7:0] cb, input int nr, input int nw);
    bit legal, isbit;
    logic [2:0] aop;
    step_t s;
    ref_decode(op, cb[7:6], legal, aop, isbit);
    if (legal) build(aop, isbit, nr, nw);
    else begin
      q.delete();
      xm = 0;
      s = blank(1'b0); s.o.illegal = 1'b1; emit(s, 1'b0);
      emit(blank(1'b0), 1'b0);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] op, input logic [7:0] cb,
                     input bit iy, input int nr, input int nw, output int lat);
    prepare(op, cb, nr, nw);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.cb_op = cb; bus.prefix_iy = iy; bus.mem_wait = 1'b0;
    lat = -1;
    foreach (q[i]) begin
      @(negedge clk);
      chk({tag, "_out"}, i + 1, 32'(sample()), 32'(q[i].o));
      if (q[i].o.busy) chk({tag, "_iy"}, i + 1, 32'(bus.idx_sel_iy), 32'(iy));
      if (bus.done === 1'b1 && lat < 0) lat = i + 1;
      bus.mem_wait = q[i].mw;
      if (q[i].o.busy) begin
        bus.start     = 1'($urandom);
        bus.opcode    = 8'($urandom);
        bus.cb_op     = 8'($urandom);
        bus.prefix_iy = 1'($urandom);
      end else bus.start = 1'b0;
    end
  endtask

  initial begin
    int lat, nr, nw, sel, i;
    bit hit;
    logic [7:0] op;

    rst = 1'b1;
    bus.start = 1'b0; bus.opcode = 8'h00; bus.cb_op = 8'h00;
    bus.prefix_iy = 1'b0; bus.mem_wait = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", 0, 32'(sample()), 32'(0));
    chk("reset_iy", 0, 32'(bus.idx_sel_iy), 32'(0));
    rst = 1'b0;

    run("inc_base", 8'h34, 8'h00, 1'b0, 0, 0, lat);
    chk("inc_lat", 0, 32'(lat), 32'(AC + 10));
    run("dec_w3", 8'h35, 8'h00, 1'b1, 3, 0, lat);
    chk("dec_w3_lat", 0, 32'(lat), 32'(AC + 13));
    run("rd_wmax", 8'h34, 8'h00, 1'b0, WM, 0, lat);
    chk("rd_wmax_lat", 0, 32'(lat), 32'(AC + 10 + WM));
    run("rd_wmax1", 8'h35, 8'h00, 1'b1, WM + 1, 0, lat);
    chk("rd_wmax1_lat", 0, 32'(lat), 32'(-1));
    run("w1_abort", 8'h34, 8'h00, 1'b1, 0, 20, lat);
    chk("w1_abort_lat", 0, 32'(lat), 32'(-1));
    run("ill_00", 8'h00, 8'h00, 1'b0, 0, 0, lat);
    run("cb_bit", 8'hCB, 8'h46, 1'b1, 0, 0, lat);
    chk("cb_bit_lat", 0, 32'(lat), CB_EN ? 32'(12) : 32'(-1));
    run("cb_set", 8'hCB, 8'hC1, 1'b0, 1, 2, lat);

    // reset while R1 is waiting, with start held high in the same cycle
    prepare(8'h34, 8'h00, 20, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 8'h34; bus.prefix_iy = 1'b1; bus.mem_wait = 1'b0;
    i = 0;
    hit = 1'b0;
    while (i < q.size() && !hit) begin
      @(negedge clk);
      chk("rst_pre_out", i + 1, 32'(sample()), 32'(q[i].o));
      if (q[i].o.rd == 3'b010) hit = 1'b1;
      else begin
        bus.start    = 1'b0;
        bus.mem_wait = q[i].mw;
      end
      i++;
    end
    chk("rst_reach_r1", 0, 32'(hit), 32'(1));
    rst = 1'b1; bus.start = 1'b1; bus.mem_wait = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", 0, 32'(sample()), 32'(0));
    chk("rst_mid_iy", 0, 32'(bus.idx_sel_iy), 32'(0));
    rst = 1'b0; bus.start = 1'b0; bus.mem_wait = 1'b0;
    @(negedge clk);
    chk("rst_idle_out", 0, 32'(sample()), 32'(0));
    run("post_rst", 8'h34, 8'h00, 1'b1, 0, 0, lat);
    chk("post_rst_lat", 0, 32'(lat), 32'(AC + 10));

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       op = 8'h34;
        1:       op = 8'h35;
        2:       op = 8'hCB;
        default: op = 8'($urandom);
      endcase
      nr = ($urandom_range(0, 7) == 0) ? WM + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      nw = ($urandom_range(0, 7) == 0) ? WM + 1 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
      run("rnd", op, 8'($urandom), 1'($urandom), nr, nw, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
